// File: rtl/sort_pkg.sv
// sort_pkg: default widths and the key comparison shared by the sorting-network stages.
package sort_pkg;

    localparam int SORT_KEY_WIDTH     = 4;
    localparam int SORT_PAYLOAD_WIDTH = 4;
    localparam int SORT_CNT_WIDTH     = 16;
    localparam int SORT_MAX_KEY_WIDTH = 64;

    // True when key a is strictly greater than key b. Keys arrive zero-extended to
    // 64 bits; for two's complement keys the sign bit of the real width is inverted
    // so that a plain unsigned compare gives the signed ordering.
    function automatic logic key_gt(
        input logic [SORT_MAX_KEY_WIDTH-1:0] a,
        input logic [SORT_MAX_KEY_WIDTH-1:0] b,
        input int unsigned                   width,
        input logic                          is_signed
    );
        logic [SORT_MAX_KEY_WIDTH-1:0] bias;
        bias = is_signed ? (64'd1 << (width - 1)) : 64'd0;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/skid_reg.sv
// skid_reg: output register backed by a one-entry skid register; up_ready is registered.
module skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] up_data,
    input  logic         up_valid,
    output logic         up_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    input  logic         dn_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic [W-1:0] out_data_next;
    logic [W-1:0] skid_data_next;
    logic         out_valid_next;
    logic         skid_valid_next;
    logic         accept;
    logic         drain;

    assign accept = up_valid & up_ready;
    assign drain  = dn_valid & dn_ready;

    // Next-state selection: drain refills from skid first, otherwise from the new pair.
    always_comb begin
        out_data_next   = dn_data;
        out_valid_next  = dn_valid;
        skid_data_next  = skid_data;
        skid_valid_next = skid_valid;
        if (drain) begin
            if (skid_valid) begin
                out_data_next   = skid_data;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_data_next  = up_data;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            if (!dn_valid) begin
                out_data_next  = up_data;
                out_valid_next = 1'b1;
            end else begin
                skid_data_next  = up_data;
                skid_valid_next = 1'b1;
            end
        end
    end

    // State registers; up_ready tracks the inverse of the upcoming skid occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_data    <= '0;
            dn_valid   <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            up_ready   <= 1'b0;
        end else begin
            dn_data    <= out_data_next;
            dn_valid   <= out_valid_next;
            skid_data  <= skid_data_next;
            skid_valid <= skid_valid_next;
            up_ready   <= !skid_valid_next;
        end
    end

endmodule

// File: rtl/cae_pipe.sv
// cae_pipe: compare-and-exchange stage with payloads, one-cycle latency and a swap counter.
module cae_pipe
    import sort_pkg::*;
#(
    parameter int KEY_WIDTH     = SORT_KEY_WIDTH,
    parameter int PAYLOAD_WIDTH = SORT_PAYLOAD_WIDTH,
    parameter int SIGNED        = 0,
    parameter int CNT_WIDTH     = SORT_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     asc,
    input  logic [KEY_WIDTH-1:0]     x1_key,
    input  logic [KEY_WIDTH-1:0]     x2_key,
    input  logic [PAYLOAD_WIDTH-1:0] x1_pay,
    input  logic [PAYLOAD_WIDTH-1:0] x2_pay,
    input  logic                     x_valid,
    output logic                     x_ready,
    output logic [KEY_WIDTH-1:0]     y1_key,
    output logic [KEY_WIDTH-1:0]     y2_key,
    output logic [PAYLOAD_WIDTH-1:0] y1_pay,
    output logic [PAYLOAD_WIDTH-1:0] y2_pay,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic                     y_swapped,
    input  logic                     cnt_clr,
    output logic [CNT_WIDTH-1:0]     swap_cnt
);

    localparam int DW = 1 + 2 * (KEY_WIDTH + PAYLOAD_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic          x1_gt;
    logic          x2_gt;
    logic          do_swap;
    logic [DW-1:0] pair_data;
    logic [DW-1:0] out_data;

    assign x1_gt = key_gt(64'(x1_key), 64'(x2_key), KEY_WIDTH, SIGNED != 0);
    assign x2_gt = key_gt(64'(x2_key), 64'(x1_key), KEY_WIDTH, SIGNED != 0);

    // Strict compare only, so equal keys keep their order; payloads travel with keys.
    always_comb begin
        do_swap   = asc ? x1_gt : x2_gt;
        pair_data = do_swap ? {1'b1, x2_key, x2_pay, x1_key, x1_pay}
                            : {1'b0, x1_key, x1_pay, x2_key, x2_pay};
    end

    skid_reg #(.W(DW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .up_data  (pair_data),
        .up_valid (x_valid),
        .up_ready (x_ready),
        .dn_data  (out_data),
        .dn_valid (y_valid),
        .dn_ready (y_ready)
    );

    assign {y_swapped, y1_key, y1_pay, y2_key, y2_pay} = out_data;

    // Saturating swap counter; a clear in the same cycle beats an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            swap_cnt <= '0;
        end else if (cnt_clr) begin
            swap_cnt <= '0;
        end else if (x_valid && x_ready && do_swap && swap_cnt != CNT_MAX) begin
            swap_cnt <= swap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cae_pipe.sv
// tb_cae_pipe: two cae_pipe instances (unsigned/2-bit counter and signed/16-bit counter)
// driven with directed and random pairs and compared against a queue-based reference.
module tb_cae_pipe;

    typedef struct packed {
        logic       sw;
        logic [3:0] k1;
        logic [3:0] p1;
        logic [3:0] k2;
        logic [3:0] p2;
    } entry_t;

    logic       clk;
    logic       rst;
    logic       asc;
    logic [3:0] x1_key, x2_key, x1_pay, x2_pay;
    logic       x_valid;
    logic       y_ready;
    logic       cnt_clr;

    logic        xr_u, yv_u, ys_u;
    logic [3:0]  y1k_u, y2k_u, y1p_u, y2p_u;
    logic [1:0]  cnt_u_dut;
    logic        xr_s, yv_s, ys_s;
    logic [3:0]  y1k_s, y2k_s, y1p_s, y2p_s;
    logic [15:0] cnt_s_dut;

    entry_t qu[$];
    entry_t qs[$];
    bit     exp_ready;
    int     cnt_u;
    int     cnt_s;
    int     compared;
    int     mismatched;

    cae_pipe #(.KEY_WIDTH(4), .PAYLOAD_WIDTH(4), .SIGNED(0), .CNT_WIDTH(2)) dut_u (
        .clk(clk), .rst(rst), .asc(asc),
        .x1_key(x1_key), .x2_key(x2_key), .x1_pay(x1_pay), .x2_pay(x2_pay),
        .x_valid(x_valid), .x_ready(xr_u),
        .y1_key(y1k_u), .y2_key(y2k_u), .y1_pay(y1p_u), .y2_pay(y2p_u),
        .y_valid(yv_u), .y_ready(y_ready), .y_swapped(ys_u),
        .cnt_clr(cnt_clr), .swap_cnt(cnt_u_dut)
    );

    cae_pipe #(.KEY_WIDTH(4), .PAYLOAD_WIDTH(4), .SIGNED(1), .CNT_WIDTH(16)) dut_s (
        .clk(clk), .rst(rst), .asc(asc),
        .x1_key(x1_key), .x2_key(x2_key), .x1_pay(x1_pay), .x2_pay(x2_pay),
        .x_valid(x_valid), .x_ready(xr_s),
        .y1_key(y1k_s), .y2_key(y2k_s), .y1_pay(y1p_s), .y2_pay(y2p_s),
        .y_valid(yv_s), .y_ready(y_ready), .y_swapped(ys_s),
        .cnt_clr(cnt_clr), .swap_cnt(cnt_s_dut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: order the two keys by plain integer comparison.
    function automatic entry_t make_entry(input bit sgn, input bit a,
                                          input logic [3:0] k1, input logic [3:0] p1,
                                          input logic [3:0] k2, input logic [3:0] p2);
        int v1, v2;
        bit sw;
        entry_t e;
        v1 = int'(k1);
        v2 = int'(k2);
        if (sgn && v1 >= 8) v1 = v1 - 16;
        if (sgn && v2 >= 8) v2 = v2 - 16;
        sw = a ? (v1 > v2) : (v1 < v2);
        if (sw) e = '{sw: 1'b1, k1: k2, p1: p2, k2: k1, p2: p1};
        else    e = '{sw: 1'b0, k1: k1, p1: p1, k2: k2, p2: p2};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        entry_t du, ds;
        du = {ys_u, y1k_u, y1p_u, y2k_u, y2p_u};
        ds = {ys_s, y1k_s, y1p_s, y2k_s, y2p_s};
        chk("x_ready_u", 32'(xr_u), 32'(exp_ready));
        chk("x_ready_s", 32'(xr_s), 32'(exp_ready));
        chk("y_valid_u", 32'(yv_u), 32'(qu.size() > 0));
        chk("y_valid_s", 32'(yv_s), 32'(qs.size() > 0));
        chk("swap_cnt_u", 32'(cnt_u_dut), 32'(cnt_u));
        chk("swap_cnt_s", 32'(cnt_s_dut), 32'(cnt_s));
        if (qu.size() > 0) begin
            chk("y_data_u", 32'(du), 32'(qu[0]));
            chk("y_data_s", 32'(ds), 32'(qs[0]));
        end else if (!rst) begin
            chk("y_data_u_rst", 32'(du), 32'd0);
            chk("y_data_s_rst", 32'(ds), 32'd0);
        end
    endtask

    // One clock edge: update the reference from pre-edge inputs, then check outputs.
    task automatic tick();
        bit live, acc, drn, clr;
        entry_t eu, es;
        live = rst;
        acc  = live && x_valid && exp_ready;
        drn  = live && (qu.size() > 0) && y_ready;
        clr  = cnt_clr;
        eu   = make_entry(1'b0, asc, x1_key, x1_pay, x2_key, x2_pay);
        es   = make_entry(1'b1, asc, x1_key, x1_pay, x2_key, x2_pay);
        @(posedge clk);
        if (live) begin
            if (drn) begin
                void'(qu.pop_front());
                void'(qs.pop_front());
            end
            if (acc) begin
                qu.push_back(eu);
                qs.push_back(es);
            end
            if (clr) cnt_u = 0;
            else if (acc && eu.sw && cnt_u < 3) cnt_u++;
            if (clr) cnt_s = 0;
            else if (acc && es.sw && cnt_s < 65535) cnt_s++;
            exp_ready = (qu.size() <= 1);
        end
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input bit v, input bit a,
                                  input logic [3:0] k1, input logic [3:0] p1,
                                  input logic [3:0] k2, input logic [3:0] p2);
        x_valid = v;
        asc     = a;
        x1_key  = k1;
        x1_pay  = p1;
        x2_key  = k2;
        x2_pay  = p2;
    endtask

    task automatic model_reset();
        qu.delete();
        qs.delete();
        exp_ready = 1'b0;
        cnt_u = 0;
        cnt_s = 0;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b0;
        cnt_clr = 1'b0;
        y_ready = 1'b1;
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        model_reset();
        #1;
        check_output();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Ascending, 9/A vs 3/B: exchange expected.
        apply_stimulus(1'b1, 1'b1, 4'd9, 4'hA, 4'd3, 4'hB);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();

        // Descending with equal keys: order kept.
        apply_stimulus(1'b1, 1'b0, 4'd5, 4'h1, 4'd5, 4'h2);
        tick();
        // Ascending -1 vs 1: signed keeps, unsigned swaps.
        apply_stimulus(1'b1, 1'b1, 4'b1111, 4'h3, 4'b0001, 4'h4);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();

        // Backpressure: three pairs offered with y_ready low, then release.
        y_ready = 1'b0;
        apply_stimulus(1'b1, 1'b1, 4'd7, 4'h1, 4'd2, 4'h2);
        tick();
        apply_stimulus(1'b1, 1'b0, 4'd1, 4'h3, 4'd6, 4'h4);
        tick();
        apply_stimulus(1'b1, 1'b1, 4'd4, 4'h5, 4'd8, 4'h6);
        tick();
        tick();
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!exp_ready) begin
                tick();
            end else begin
                tick();
                apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
            end
        end
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();

        // Five swapping pairs to saturate the 2-bit counter, then clear with a swap.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 1'b1, 4'd6, 4'(i), 4'd2, 4'hF);
            tick();
        end
        cnt_clr = 1'b1;
        apply_stimulus(1'b1, 1'b1, 4'd6, 4'h9, 4'd2, 4'hE);
        tick();
        cnt_clr = 1'b0;
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(($urandom % 4) != 0, 1'($urandom), 4'($urandom), 4'($urandom),
                           4'($urandom), 4'($urandom));
            y_ready = ($urandom % 3) != 0;
            cnt_clr = ($urandom % 25) == 0;
            tick();
        end
        cnt_clr = 1'b0;

        // Reset with both registers full: outputs drop at once, nothing old returns.
        y_ready = 1'b1;
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        tick();
        tick();
        y_ready = 1'b0;
        apply_stimulus(1'b1, 1'b1, 4'd9, 4'h1, 4'd3, 4'h2);
        tick();
        apply_stimulus(1'b1, 1'b0, 4'd2, 4'h3, 4'd8, 4'h4);
        tick();
        apply_stimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_output();
        tick();
        rst = 1'b1;
        y_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cae_pipe.md
CAE_PIPE -- requirements
Module: cae_pipe

Interface
REQ-001 Parameter KEY_WIDTH, default 4: width of the compared key field; SHALL be at least 1.
REQ-002 Parameter PAYLOAD_WIDTH, default 4: width of the payload carried with each key without being compared; SHALL be at least 1.
REQ-003 Parameter SIGNED, default 0: 0 compares keys as unsigned, 1 compares them as two's complement.
REQ-004 Parameter CNT_WIDTH, default 16: width of the swap counter.
REQ-005 Port clk, input, 1: the single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port asc, input, 1: direction, sampled with each accepted pair; 1 gives ascending order, 0 gives descending.
REQ-008 Ports x1_key and x2_key, input, KEY_WIDTH each: the input keys.
REQ-009 Ports x1_pay and x2_pay, input, PAYLOAD_WIDTH each: the input payloads.
REQ-010 Ports x_valid (input, 1) and x_ready (output, 1): input handshake.
REQ-011 Ports y1_key and y2_key, output, KEY_WIDTH each: the output keys.
REQ-012 Ports y1_pay and y2_pay, output, PAYLOAD_WIDTH each: the output payloads.
REQ-013 Ports y_valid (output, 1) and y_ready (input, 1): output handshake.
REQ-014 Port y_swapped, output, 1: set when the current output pair was exchanged.
REQ-015 Port cnt_clr (input, 1): synchronous clear of the swap counter.
REQ-016 Port swap_cnt (output, CNT_WIDTH): the saturating swap count.

Function
REQ-017 A transfer SHALL occur on an edge where valid and ready are both high; no other edge SHALL transfer a pair.
REQ-018 Swap rule, ascending: swap when x1_key > x2_key. Swap rule, descending: swap when x1_key < x2_key.
REQ-019 Equal keys SHALL never swap, so that sorting is stable.
REQ-020 Each payload SHALL move with its own key.
REQ-021 Latency SHALL be 1 cycle: a pair accepted at edge N SHALL be presented on the y_* ports after edge N, with y_valid high.
REQ-022 The outputs SHALL come from an output register backed by a one-entry skid register.
REQ-023 x_ready SHALL be a registered signal equal to NOT skid_valid and SHALL NOT depend combinationally on y_ready.
REQ-024 An accepted pair SHALL load the output register when that register is empty or is draining in the same cycle; otherwise it SHALL load the skid register.
REQ-025 When the output register drains while the skid register is full, the skid contents SHALL move to the output register and the skid register SHALL empty.
REQ-026 Simultaneous accept and drain with the skid register empty SHALL replace the output register, giving full throughput.
REQ-027 While y_valid is high and y_ready is low, the y_* ports and y_swapped SHALL hold stable.
REQ-028 Pairs SHALL leave in acceptance order, with no loss and no duplication.
REQ-029 swap_cnt SHALL increment by 1 on each accepted pair that swaps.
REQ-030 swap_cnt SHALL saturate at 2^CNT_WIDTH-1.
REQ-031 When cnt_clr is high in the same cycle as an increment, cnt_clr SHALL win and the next swap_cnt value SHALL be 0.

Reset
REQ-032 Asserting rst (low) SHALL asynchronously force y_valid, the skid-valid flag, y_swapped, swap_cnt and all data registers to 0.
REQ-033 x_ready SHALL read 1 one cycle after rst deasserts (rising) and SHALL stay 0 while rst is low.
REQ-034 Reset in the middle of an operation SHALL discard both held pairs; no stale pair SHALL appear on the outputs after reset.

Structure
REQ-035 A shared package (sort_pkg) SHALL hold the default widths and the comparison function, parameterised by signedness, for reuse by later network stages.
REQ-036 The skid register/handshake pair SHALL be a sub-module named skid_reg, parameterised by data width.
REQ-037 The comparator and swap mux SHALL be combinational and sit ahead of skid_reg.
REQ-038 skid_reg SHALL carry the keys, payloads and swap flag.

Verification
REQ-039 Scenario: asc=1, x1_key=9, x2_key=3, payloads A/B, y_ready=1 -> next cycle y1_key=3/B, y2_key=9/A, y_swapped=1, swap_cnt=1.
REQ-040 Scenario: asc=0, keys 5 and 5 -> outputs unchanged in order, y_swapped=0, swap_cnt unchanged.
REQ-041 Scenario: SIGNED=1, KEY_WIDTH=4, asc=1, keys 4'b1111 (-1) and 4'b0001 (1) -> no swap. Same keys with SIGNED=0 -> swap.
REQ-042 Scenario: y_ready held 0 while 3 back-to-back pairs are offered -> 2 pairs accepted, x_ready=0 thereafter. Then release y_ready -> both pairs emerge in order, then the third is accepted.
REQ-043 Scenario: CNT_WIDTH=2, 5 swapping pairs -> swap_cnt stays at 3; cnt_clr together with a swapping pair -> swap_cnt=0.
REQ-044 Scenario: rst asserted low with both registers full -> y_valid=0 immediately. After release, x_ready=1 and no old data emerges.
